// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed XLEN+2 cycle latency, result delivered as a one-cycle register-file write.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [AW-1:0]   rd,
  output logic            busy,
  output logic            done,
  output logic            wb_load,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state_reg;
  logic [CW-1:0]     count_reg;
  logic [2:0]        op_reg;
  logic [AW-1:0]     rd_reg;
  logic [XLEN-1:0]   mag_a_reg, mag_b_reg;
  logic              neg_a_reg, neg_b_reg;
  logic              div_zero_reg, ovf_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              done_reg, wb_load_reg;
  logic [AW-1:0]     wb_addr_reg;
  logic [XLEN-1:0]   wb_data_reg;

  logic              a_signed, b_signed, accept;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, a_orig, result;

  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    mag_a_in = (a_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    mag_b_in = (b_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    accept   = start && !flush && ((state_reg == IDLE) || (state_reg == DONE));
  end

  // acc_reg holds {high, low}: product/multiplier for multiply, remainder/quotient for divide
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_reg[0]}} & mag_a_reg};
    div_trial = acc_reg[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, mag_b_reg};
    if (op_reg[2]) begin
      acc_step = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    quo_fix  = (neg_a_reg ^ neg_b_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix  = neg_a_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    a_orig   = neg_a_reg ? -mag_a_reg : mag_a_reg;
    case (op_reg)
      3'd0:             result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: begin
        if (div_zero_reg)  result = '1;
        else if (ovf_reg)  result = {1'b1, {(XLEN-1){1'b0}}};
        else               result = quo_fix;
      end
      default: begin
        if (div_zero_reg)  result = a_orig;
        else if (ovf_reg)  result = '0;
        else               result = rem_fix;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      op_reg       <= '0;
      rd_reg       <= '0;
      mag_a_reg    <= '0;
      mag_b_reg    <= '0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      acc_reg      <= '0;
      done_reg     <= 1'b0;
      wb_load_reg  <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
    end else begin
      done_reg    <= 1'b0;
      wb_load_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            state_reg    <= CALC;
            count_reg    <= '0;
            op_reg       <= funct3;
            rd_reg       <= rd;
            mag_a_reg    <= mag_a_in;
            mag_b_reg    <= mag_b_in;
            neg_a_reg    <= a_signed && rs1_val[XLEN-1];
            neg_b_reg    <= b_signed && rs2_val[XLEN-1];
            div_zero_reg <= (rs2_val == '0);
            ovf_reg      <= ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                            (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
            acc_reg      <= funct3[2] ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg   <= acc_step;
            count_reg <= count_reg + CW'(1);
            if (count_reg == CW'(XLEN-1)) state_reg <= FIXUP;
          end
        end
        FIXUP: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            wb_load_reg <= (rd_reg != '0);
            wb_addr_reg <= rd_reg;
            wb_data_reg <= result;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = (state_reg == CALC) || (state_reg == FIXUP);
  assign done    = done_reg;
  assign wb_load = wb_load_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_data = wb_data_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a behavioural RV32M model predicts each
// write-back, the monitor checks address, data, load strobe and latency.
module tb_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;
  logic        busy, done, wb_load;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  muldiv_unit #(.XLEN(32), .AW(5)) dut (
    .clock(clock), .reset(reset), .start(start), .flush(flush),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .busy(busy), .done(done), .wb_load(wb_load), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [4:0]  rd;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb2;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb2);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb2);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // latency counts rising edges from the accept edge to the edge where done is seen high
  always @(negedge clock) begin
    if (reset && wb_load && !done) check("load_without_done", wb_load, 1'b0);
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s: rd=%0d data=0x%08h load=%0b latency=%0d", e.tag, wb_addr, wb_data, wb_load, cyc - e.acc + 1);
        check({e.tag, "_addr"}, wb_addr, e.rd);
        check({e.tag, "_data"}, wb_data, e.data);
        check({e.tag, "_load"}, wb_load, e.rd != 5'd0);
        check({e.tag, "_latency"}, cyc - e.acc + 1, 34);
      end
    end
  end

  // called at a negedge; start is held across exactly one rising edge
  task automatic drive_start(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] d, input bit expect_accept);
    exp_t e;
    funct3 = f; rs1_val = a; rs2_val = b; rd = d; start = 1'b1;
    if (expect_accept) begin
      e.tag = tag; e.rd = d; e.data = model(f, a, b); e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
    @(negedge clock);
    drive_start(tag, f, a, b, d, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(int'($urandom_range(0, 20)));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd = 5'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load", wb_load, 1'b0);
    check("rst_addr", wb_addr, 5'd0);
    check("rst_data", wb_data, 32'd0);
    reset = 1'b1;

    // MUL with busy-window measurement
    issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("mul_busy_len", n, 33);
    drain();

    issue("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);  drain();
    issue("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);  drain();
    issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);  drain();
    issue("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);          drain();
    issue("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);          drain();
    issue("divu",   3'd5, 32'd100, 32'd7, 5'd7);                drain();
    issue("remu",   3'd7, 32'd100, 32'd7, 5'd8);                drain();
    issue("divu0",  3'd5, 32'd5, 32'd0, 5'd9);                  drain();
    issue("rem0",   3'd6, 32'd5, 32'd0, 5'd10);                 drain();
    issue("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11); drain();
    issue("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12); drain();

    // start while busy is ignored
    issue("busy_op", 3'd5, 32'd1000, 32'd3, 5'd13);
    repeat (4) @(negedge clock);
    drive_start("busy_start", 3'd0, 32'd3, 32'd3, 5'd14, 1'b0);
    drain();

    // flush in the tenth CALC cycle
    issue("flushed", 3'd0, 32'd9, 32'd9, 5'd15);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    void'(sb.pop_back());
    check("flush_busy", busy, 1'b0);
    repeat (40) @(negedge clock);

    // flush together with start in IDLE
    flush = 1'b1;
    drive_start("flush_start", 3'd0, 32'd2, 32'd2, 5'd16, 1'b0);
    flush = 1'b0;
    check("flush_start_busy", busy, 1'b0);
    repeat (40) @(negedge clock);

    // reset mid-op, then a fresh op
    issue("reset_op", 3'd4, 32'd77, 32'd5, 5'd17);
    repeat (19) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_load", wb_load, 1'b0);
    check("mid_rst_addr", wb_addr, 5'd0);
    check("mid_rst_data", wb_data, 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    issue("post_rst", 3'd7, 32'hFFFF_FFFF, 32'd10, 5'd18);
    drain();

    // rd=0, then back-to-back start during DONE
    issue("rd0", 3'd0, 32'd6, 32'd7, 5'd0);
    repeat (33) @(negedge clock);
    drive_start("b2b", 3'd4, 32'hFFFF_FF00, 32'd16, 5'd19, 1'b1);
    drain();

    // flush in DONE: write completes, same-cycle start ignored
    issue("flush_done", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
    repeat (33) @(negedge clock);
    flush = 1'b1;
    drive_start("flush_done_start", 3'd0, 32'd5, 32'd5, 5'd21, 1'b0);
    flush = 1'b0;
    check("flush_done_busy", busy, 1'b0);
    drain();
    repeat (40) @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      issue($sformatf("rand%0d_f%0d", i, f), f, a, b, 5'($urandom_range(0, 31)));
      drain();
    end

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit between the execute stage and the register file write port.
- Accepts one M-extension op with operands already read from the register file, and computes it over a fixed number of cycles.
- Presents the result as a single-cycle write (load/waddr/data) that drives the register file's write port directly.

Parameters:
XLEN, 32, operand/result width (matches register file DW)
AW, 5, register address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; accepted only when busy=0
flush  in  1  kill in-flight op (pipeline redirect)
funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_val  in  XLEN  operand A (dividend / multiplicand)
rs2_val  in  XLEN  operand B (divisor / multiplier)
rd  in  AW  destination register
busy  out  1  op in flight; start ignored
done  out  1  one-cycle pulse, result valid
wb_load  out  1  register file load strobe
wb_addr  out  AW  register file waddr
wb_data  out  XLEN  register file data

Behaviour:
- States: IDLE, CALC, FIXUP, DONE.
- busy = (state==CALC || state==FIXUP).
- Accept on a rising edge with start=1, busy=0, flush=0. Capture funct3, rd, operand magnitudes and sign flags. Clear accumulator and counter. Go to CALC.
- Signedness of operands:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - MUL uses the low word, so sign handling is irrelevant there.
- CALC runs exactly XLEN cycles, counter 0..XLEN-1.
  - Multiply: shift-add on magnitudes into a 2*XLEN-bit product.
  - Divide: restoring division on magnitudes, one quotient bit per cycle.
- At count XLEN-1, go to FIXUP (one cycle):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Select the result: MUL = low word; MULH/MULHSU/MULHU = high word; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE (one cycle): done=1, wb_addr=captured rd, wb_data=result, wb_load=1 unless rd==0 (done still pulses). Next state is IDLE, or CALC if start is accepted this cycle (back-to-back allowed since busy=0 in DONE).
- Latency: accept edge to done high = XLEN+2 cycles, identical for every funct3 and for all special cases.
- Divide by zero (DIV/DIVU): quotient = all ones. REM/REMU: remainder = rs1_val.
- Overflow (DIV of 0x80000000 by 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Special cases are detected at accept and forced in FIXUP; the iteration still runs so latency stays constant.
- flush=1 in IDLE/CALC/FIXUP: next state IDLE, no done, no wb_load.
- flush=1 in DONE: the write still completes (already committed), and a same-cycle start is ignored.
- flush and start together in IDLE: flush wins, nothing accepted.
- Outputs are registered. wb_data and wb_addr hold their last values outside DONE; wb_load and done are 0 outside DONE.
- Reset low (any time, including mid-op): state IDLE, busy=0, done=0, wb_load=0, wb_addr=0, wb_data=0, counter=0. The in-flight op is discarded.

Test Plan:
- MUL 7 × 0xFFFFFFFD, rd=5 -> busy high XLEN+1 cycles; done and wb_load pulse once at cycle 34 after accept; wb_addr=5, wb_data=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All at latency 34.
- start pulsed while busy -> ignored. flush at cycle 10 of CALC -> no done. Reset driven low at cycle 20 of CALC -> all outputs 0 asynchronously, busy=0, and a new op afterwards completes correctly.
- rd=0 -> done pulses, wb_load stays 0. New start asserted during the DONE cycle -> accepted, second done exactly 34 cycles later.
